// File: rtl/peak_rate_meter.sv
// peak_rate_meter: turns the peak detector's foundPeak level into an averaged
// heart rate. It synchronises the level and detects rising edges, measures
// beat-to-beat intervals in ms, rejects refractory intervals, averages the
// last four intervals and divides 60000 by the average with a serial divider.
// Optional feature macro: BPM_HOLD_EN (timeout keeps the last bpm value and
// drops only bpm_valid).
module peak_rate_meter #(
  parameter int TICK_DIV   = 40000,
  parameter int MIN_IVL_MS = 300,
  parameter int MAX_IVL_MS = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       peak_in,
  output logic       beat,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       timeout,
  output logic       busy
);

  localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [11:0]        MIN_IVL    = 12'(MIN_IVL_MS);
  localparam logic [11:0]        MAX_IVL    = 12'(MAX_IVL_MS);
  localparam logic [15:0]        DIVIDEND   = 16'd60000;
  localparam logic [4:0]         DIV_LAST   = 5'd16;

  typedef enum logic [1:0] {WAIT_FIRST, RUN, DIV} state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_prev;
  logic [PRESC_W-1:0] r_presc;
  logic [11:0]        r_ivl;
  logic [11:0]        r_ring [4];
  logic [1:0]         r_wptr;
  logic [13:0]        r_sum;
  logic [2:0]         r_fill;
  logic [4:0]         r_cnt;
  logic [11:0]        r_divisor;
  logic [12:0]        r_rem;
  logic [15:0]        r_quo;

  logic               w_edge;
  logic               w_tick;
  logic               w_timeout;
  logic               w_accept_first;
  logic               w_accept_run;
  logic               w_accept;
  logic [2:0]         w_fill_nxt;
  logic [13:0]        w_sum_nxt;

  // Millisecond counter increment, saturating at the timeout limit.
  function automatic logic [11:0] f_ivl_inc(input logic [11:0] v);
    f_ivl_inc = (v >= MAX_IVL) ? MAX_IVL : v + 12'd1;
  endfunction

  // Ring fill count increment, saturating at a full ring of four.
  function automatic logic [2:0] f_fill_inc(input logic [2:0] f);
    f_fill_inc = (f >= 3'd4) ? 3'd4 : f + 3'd1;
  endfunction

  // One restoring-division step: shift the next dividend bit into the
  // remainder, subtract the divisor when it fits, shift the quotient bit in.
  // The remainder stays below the divisor, so the shifted value fits 13 bits.
  function automatic logic [28:0] f_div_step(input logic [12:0] rem,
                                             input logic [15:0] quo,
                                             input logic [11:0] dvs);
    logic [13:0] sh;
    sh = {rem, quo[15]};
    if (sh >= {2'b00, dvs})
      f_div_step = {13'(sh - {2'b00, dvs}), quo[14:0], 1'b1};
    else
      f_div_step = {13'(sh), quo[14:0], 1'b0};
  endfunction

  assign w_edge         = r_sync2 & ~r_prev;
  assign w_tick         = (r_presc == PRESC_LAST);
  assign w_timeout      = (r_state == RUN) && (r_ivl >= MAX_IVL);
  assign w_accept_first = (r_state == WAIT_FIRST) && w_edge;
  assign w_accept_run   = (r_state == RUN) && !w_timeout && w_edge && (r_ivl >= MIN_IVL);
  assign w_accept       = w_accept_first | w_accept_run;
  assign w_fill_nxt     = f_fill_inc(r_fill);
  assign w_sum_nxt      = r_sum + {2'b00, r_ivl} - {2'b00, r_ring[r_wptr]};

  // Two-flop synchroniser for the asynchronous peak level plus edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= peak_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Millisecond timebase: idle while waiting for the first beat, restarted
  // by every accepted beat and by a timeout, free-running otherwise (also
  // while the divider works).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_ivl   <= '0;
    end else if ((r_state == WAIT_FIRST) || w_accept || w_timeout) begin
      r_presc <= '0;
      r_ivl   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick)
        r_ivl <= f_ivl_inc(r_ivl);
    end
  end

  // Beat/interval FSM with the averaging ring and the serial divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= WAIT_FIRST;
      for (int i = 0; i < 4; i++) r_ring[i] <= '0;
      r_wptr    <= '0;
      r_sum     <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      beat      <= 1'b0;
      timeout   <= 1'b0;
      bpm       <= '0;
      bpm_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      beat    <= w_accept;
      timeout <= w_timeout;
      case (r_state)
        WAIT_FIRST: begin
          if (w_edge)
            r_state <= RUN;
        end
        RUN: begin
          if (w_timeout) begin
            for (int i = 0; i < 4; i++) r_ring[i] <= '0;
            r_wptr    <= '0;
            r_sum     <= '0;
            r_fill    <= '0;
            bpm_valid <= 1'b0;
`ifdef BPM_HOLD_EN
            bpm       <= bpm;
`else
            bpm       <= '0;
`endif
            r_state   <= WAIT_FIRST;
          end else if (w_accept_run) begin
            r_ring[r_wptr] <= r_ivl;
            r_sum          <= w_sum_nxt;
            r_wptr         <= r_wptr + 2'd1;
            r_fill         <= w_fill_nxt;
            r_cnt          <= '0;
            if (w_fill_nxt == 3'd4)
              r_state <= DIV;
          end
        end
        DIV: begin
          if (r_cnt == 5'd0) begin
            // Load: divisor is the floor average of the four intervals.
            r_divisor <= r_sum[13:2];
            r_rem     <= '0;
            r_quo     <= DIVIDEND;
            busy      <= 1'b1;
            r_cnt     <= 5'd1;
          end else if (r_cnt <= DIV_LAST) begin
            {r_rem, r_quo} <= f_div_step(r_rem, r_quo, r_divisor);
            if (r_cnt == DIV_LAST)
              busy <= 1'b0;
            r_cnt <= r_cnt + 5'd1;
          end else begin
            // Average lies in 300..2000 ms, so the quotient fits 8 bits.
            bpm       <= r_quo[7:0];
            bpm_valid <= 1'b1;
            r_cnt     <= '0;
            r_state   <= RUN;
          end
        end
        default: r_state <= WAIT_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_rate_meter.sv
// tb_peak_rate_meter: directed stimulus for peak_rate_meter with a
// millisecond-level reference model and literal expectations.
module tb_peak_rate_meter;

  localparam int TD   = 5;
  localparam int MINV = 300;
  localparam int MAXV = 2000;
`ifdef BPM_HOLD_EN
  localparam int TO_BPM = 60;
`else
  localparam int TO_BPM = 0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       peak_in = 1'b0;
  logic       beat;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       timeout;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nbeats = 0;
  int t_anchor = 0;

  // reference model state
  bit   h1 = 0, h2 = 0, h3 = 0;
  int   m_t = 0, m_last = 0, m_div = 0, m_st = 0;
  int   m_q[$];
  bit   e_beat = 0, e_to = 0, e_valid = 0, e_busy = 0;
  int   e_bpm = 0;

  peak_rate_meter #(
    .TICK_DIV  (TD),
    .MIN_IVL_MS(MINV),
    .MAX_IVL_MS(MAXV)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .peak_in  (peak_in),
    .beat     (beat),
    .bpm      (bpm),
    .bpm_valid(bpm_valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: beats, intervals in whole ms since the last accepted
  // beat, average of the last four intervals, result 18 cycles after a beat.
  initial begin
    bit edge_now;
    int ivl;
    int sum;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        h1 = 0; h2 = 0; h3 = 0;
        m_st = 0; m_last = 0; m_div = 0;
        m_q.delete();
        e_beat = 0; e_to = 0; e_valid = 0; e_busy = 0; e_bpm = 0;
      end else begin
        m_t++;
        edge_now = h2 && !h3;
        h3 = h2; h2 = h1; h1 = peak_in;
        e_beat = 0;
        e_to = 0;
        ivl = (m_t - 1 - m_last) / TD;
        if (ivl > MAXV) ivl = MAXV;
        if (m_st == 0) begin
          if (edge_now) begin
            e_beat = 1; m_last = m_t; m_st = 1;
          end
        end else if (m_st == 1) begin
          if (ivl >= MAXV) begin
            e_to = 1; m_q.delete(); e_valid = 0; m_st = 0;
`ifndef BPM_HOLD_EN
            e_bpm = 0;
`endif
          end else if (edge_now && ivl >= MINV) begin
            e_beat = 1; m_last = m_t;
            m_q.push_back(ivl);
            if (m_q.size() > 4) void'(m_q.pop_front());
            if (m_q.size() == 4) begin
              m_st = 2; m_div = m_t;
            end
          end
        end else begin
          if (m_t - m_div == 18) begin
            sum = 0;
            foreach (m_q[i]) sum += m_q[i];
            e_bpm = 60000 / (sum / 4);
            e_valid = 1;
            m_st = 1;
          end
        end
        e_busy = (m_st == 2) && (m_t - m_div >= 1) && (m_t - m_div <= 16);
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("beat", beat, e_beat);
      check("timeout", timeout, e_to);
      check("busy", busy, e_busy);
      check("bpm_valid", bpm_valid, e_valid);
      check("bpm", bpm, e_bpm);
      if (beat === 1'b1) nbeats++;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Raise peak_in ms*TD+2 cycles after the anchor rise and hold it.
  task automatic rise(input int ms, input int hold, input bit anchor);
    wait_until(t_anchor + ms * TD + 2);
    if (anchor) t_anchor = cyc;
    peak_in = 1'b1;
    repeat (hold) @(negedge clk);
    peak_in = 1'b0;
  endtask

  task automatic wait_beat(input string name);
    int n = 0;
    while (beat !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(name, beat, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_beat"}, beat, 0);
    check({tag, "_bpm"}, bpm, 0);
    check({tag, "_valid"}, bpm_valid, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    int nb;
    int nb0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #1 rst_n = 1'b1;

    // Reset asserted while a beat pulse is high.
    repeat (2) @(negedge clk);
    t_anchor = cyc;
    rise(0, 4, 1);
    wait_until(t_anchor + 400 * TD + 2);
    t_anchor = cyc;
    peak_in = 1'b1;
    wait_beat("pre_reset_beat");
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    peak_in = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Five beats 1000 ms apart -> 60 BPM, 18 cycles after the fifth beat.
    repeat (4) @(negedge clk);
    t_anchor = cyc;
    rise(0, 4, 1);
    repeat (3) rise(1000, 4, 1);
    wait_until(t_anchor + 1000 * TD + 2);
    t_anchor = cyc;
    peak_in = 1'b1;
    wait_beat("beat5");
    check("valid_before_5th", bpm_valid, 0);
    n = 0;
    nb = 0;
    while (bpm_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) nb++;
    end
    check("latency60", n, 18);
    check("busy_cycles", nb, 16);
    check("bpm60", bpm, 60);
    check("valid60", bpm_valid, 1);
    peak_in = 1'b0;

    // No beat for 2000 ms -> timeout pulse.
    n = 0;
    while (timeout !== 1'b1 && n < MAXV * TD + 60) begin
      @(negedge clk);
      n++;
    end
    check("timeout_pulse", timeout, 1);
    check("timeout_time", n, MAXV * TD + 1 - 18);
    check("timeout_valid", bpm_valid, 0);
    check("timeout_bpm", bpm, TO_BPM);

    // Fresh start: 750, 750, 1000, 500 -> 80 BPM; then 600 -> 84 BPM.
    repeat (5) @(negedge clk);
    t_anchor = cyc;
    rise(0, 4, 1);
    rise(750, 4, 1);
    nb0 = nbeats;
    rise(150, 2, 0);
    repeat (6) @(negedge clk);
    check("ignored150_beats", nbeats - nb0, 0);
    rise(750, 4, 1);
    nb0 = nbeats;
    rise(1000, 250, 1);
    check("held50_beats", nbeats - nb0, 1);
    check("valid_after_3ivl", bpm_valid, 0);
    rise(500, 4, 1);
    repeat (30) @(negedge clk);
    check("bpm80", bpm, 80);
    check("valid80", bpm_valid, 1);
    rise(600, 4, 1);
    repeat (30) @(negedge clk);
    check("bpm84", bpm, 84);

    // 299 ms is refractory, 300 ms is accepted; four 300 ms -> 200 BPM.
    nb0 = nbeats;
    rise(299, 2, 0);
    repeat (6) @(negedge clk);
    check("ignored299_beats", nbeats - nb0, 0);
    rise(300, 2, 1);
    repeat (3) rise(300, 4, 1);
    repeat (30) @(negedge clk);
    check("bpm200", bpm, 200);

    // Reset while the divider runs aborts the calculation.
    wait_until(t_anchor + 300 * TD + 2);
    t_anchor = cyc;
    peak_in = 1'b1;
    wait_beat("beat_div_abort");
    repeat (8) @(negedge clk);
    check("busy_mid_div", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("div_reset");
    peak_in = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("after_abort_valid", bpm_valid, 0);
    check("after_abort_bpm", bpm, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
